// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised VGA timing from the system clock with a pixel-rate enable, syncs, coordinates and frame pulses.
module vga_timing_gen #(
  parameter int H_ACTIVE    = 640,
  parameter int H_FP        = 16,
  parameter int H_SYNC      = 96,
  parameter int H_BP        = 48,
  parameter int V_ACTIVE    = 480,
  parameter int V_FP        = 10,
  parameter int V_SYNC      = 2,
  parameter int V_BP        = 33,
  parameter int CLK_DIV     = 4,
  parameter int SCALE_SHIFT = 2,
  parameter int HS_POL      = 0,
  parameter int VS_POL      = 0,
  parameter int CNT_W       = 10,
  parameter int FRAME_W     = 8
) (
  input  logic               clock,
  input  logic               rst,
  output logic               pix_en,
  output logic               horiz_sync,
  output logic               vert_sync,
  output logic               video_on,
  output logic [CNT_W-1:0]   pixel_row,
  output logic [CNT_W-1:0]   pixel_column,
  output logic [CNT_W-1:0]   scaled_row,
  output logic [CNT_W-1:0]   scaled_col,
  output logic               line_start,
  output logic               frame_start,
  output logic [FRAME_W-1:0] frame_count
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DIV_W = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
  localparam int HS_START = H_ACTIVE + H_FP;
  localparam int VS_START = V_ACTIVE + V_FP;
  localparam logic HP = 1'(HS_POL);
  localparam logic VP = 1'(VS_POL);
  logic [DIV_W-1:0] div;
  logic [CNT_W-1:0] hcnt, vcnt;
  logic [CNT_W:0] hx, vx;
  logic step, div_last, h_last, v_last, act, hs_on, vs_on, at_origin_h, at_origin;
  always_comb begin
    hx = {1'b0, hcnt};
    vx = {1'b0, vcnt};
    div_last = div == DIV_W'(CLK_DIV - 1);
    h_last = hcnt == CNT_W'(H_TOTAL - 1);
    v_last = vcnt == CNT_W'(V_TOTAL - 1);
    act = (hx < (CNT_W+1)'(H_ACTIVE)) && (vx < (CNT_W+1)'(V_ACTIVE));
    hs_on = (hx >= (CNT_W+1)'(HS_START)) && (hx < (CNT_W+1)'(HS_START + H_SYNC));
    vs_on = (vx >= (CNT_W+1)'(VS_START)) && (vx < (CNT_W+1)'(VS_START + V_SYNC));
    // step marks the clock right after a counter update, so a zero count here means a fresh wrap
    at_origin_h = step && (hcnt == '0);
    at_origin = at_origin_h && (vcnt == '0);
  end
  always_ff @(posedge clock) begin
    if (rst) begin
      div          <= '0;
      hcnt         <= '0;
      vcnt         <= '0;
      step         <= 1'b0;
      pix_en       <= 1'b0;
      video_on     <= 1'b0;
      horiz_sync   <= ~HP;
      vert_sync    <= ~VP;
      pixel_row    <= '0;
      pixel_column <= '0;
      scaled_row   <= '0;
      scaled_col   <= '0;
      line_start   <= 1'b0;
      frame_start  <= 1'b0;
      frame_count  <= '0;
    end else begin
      div    <= div_last ? '0 : div + DIV_W'(1);
      pix_en <= div_last;
      step   <= pix_en;
      if (pix_en) begin
        hcnt <= h_last ? '0 : hcnt + CNT_W'(1);
        if (h_last) vcnt <= v_last ? '0 : vcnt + CNT_W'(1);
      end
      video_on     <= act;
      horiz_sync   <= hs_on ? HP : ~HP;
      vert_sync    <= vs_on ? VP : ~VP;
      pixel_row    <= vcnt;
      pixel_column <= hcnt;
      scaled_row   <= vcnt >> SCALE_SHIFT;
      scaled_col   <= hcnt >> SCALE_SHIFT;
      line_start   <= at_origin_h;
      frame_start  <= at_origin;
      frame_count  <= frame_count + FRAME_W'(at_origin);
    end
  end
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: directed bench over default, small and inverted-polarity configurations with a FIFO scoreboard.
module tb_vga_timing_gen;
  logic clock = 1'b0;
  logic rst = 1'b1;
  always #5 clock = ~clock;

  logic d_pe, d_hs, d_vs, d_von, d_ls, d_fs;
  logic [9:0] d_row, d_col, d_srow, d_scol;
  logic [7:0] d_fc;
  logic s_pe, s_hs, s_vs, s_von, s_ls, s_fs;
  logic [9:0] s_row, s_col, s_srow, s_scol;
  logic [1:0] s_fc;
  logic p_pe, p_hs, p_vs, p_von, p_ls, p_fs;
  logic [9:0] p_row, p_col, p_srow, p_scol;
  logic [7:0] p_fc;

  vga_timing_gen dut (
    .clock(clock), .rst(rst), .pix_en(d_pe), .horiz_sync(d_hs), .vert_sync(d_vs),
    .video_on(d_von), .pixel_row(d_row), .pixel_column(d_col), .scaled_row(d_srow),
    .scaled_col(d_scol), .line_start(d_ls), .frame_start(d_fs), .frame_count(d_fc)
  );

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2), .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .CLK_DIV(1), .SCALE_SHIFT(1), .FRAME_W(2)
  ) dut_s (
    .clock(clock), .rst(rst), .pix_en(s_pe), .horiz_sync(s_hs), .vert_sync(s_vs),
    .video_on(s_von), .pixel_row(s_row), .pixel_column(s_col), .scaled_row(s_srow),
    .scaled_col(s_scol), .line_start(s_ls), .frame_start(s_fs), .frame_count(s_fc)
  );

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2), .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .CLK_DIV(1), .SCALE_SHIFT(1), .HS_POL(1), .VS_POL(1)
  ) dut_p (
    .clock(clock), .rst(rst), .pix_en(p_pe), .horiz_sync(p_hs), .vert_sync(p_vs),
    .video_on(p_von), .pixel_row(p_row), .pixel_column(p_col), .scaled_row(p_srow),
    .scaled_col(p_scol), .line_start(p_ls), .frame_start(p_fs), .frame_count(p_fc)
  );

  int errors = 0;
  int checks = 0;
  int exp_q[$];
  string tag_q[$];

  task automatic expect_val(input string tag, input int v);
    tag_q.push_back(tag);
    exp_q.push_back(v);
  endtask

  task automatic check(input int obs);
    string t;
    int e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $error("FAIL scoreboard_empty observed=%0d expected=none", obs);
      return;
    end
    t = tag_q.pop_front();
    e = exp_q.pop_front();
    assert (obs === e) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", t, obs, e);
    end
  endtask

  initial begin
    int first_pe, v1, c1, spe1, spulse, n, t;
    int hs_low, hs_first, von, pe_last, pe_bad, pe_n, row0, row_hold, row_changed;
    int prev_col, prev_von, edge_ok;
    int fs_seen, last_fs, last_ls, per_bad, coinc_bad, fc_bad, ls_bad, ls_n;
    int vs_low, vs_bad, sc_n, sc_bad, p_hs_n, p_vs_n, pol_bad, prev_fc;

    repeat (2) @(negedge clock);
    rst = 1'b0;
    repeat (1000) @(negedge clock);
    rst = 1'b1;
    repeat (3) @(negedge clock);
    expect_val("rst_col", 0);       check(d_col);
    expect_val("rst_row", 0);       check(d_row);
    expect_val("rst_video_on", 0);  check(d_von);
    expect_val("rst_pix_en", 0);    check(d_pe);
    expect_val("rst_hs", 1);        check(d_hs);
    expect_val("rst_vs", 1);        check(d_vs);
    expect_val("rst_s_fc", 0);      check(s_fc);
    expect_val("rst_s_pulses", 0);  check(s_ls | s_fs);
    expect_val("rst_p_hs", 0);      check(p_hs);
    expect_val("rst_p_vs", 0);      check(p_vs);

    rst = 1'b0;
    first_pe = 0; v1 = -1; c1 = -1; spe1 = -1; spulse = 0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clock);
      if (k == 1) begin v1 = d_von; c1 = d_col; spe1 = s_pe; end
      if (d_pe && first_pe == 0) first_pe = k;
      spulse += s_ls + s_fs;
    end
    expect_val("rel_video_on_c1", 1);  check(v1);
    expect_val("rel_col_c1", 0);       check(c1);
    expect_val("rel_first_pix_en", 4); check(first_pe);
    expect_val("rel_s_pix_en_c1", 1);  check(spe1);
    expect_val("rel_no_pulse", 0);     check(spulse);

    n = 0;
    while (!d_ls && n < 4000) begin @(negedge clock); n++; end
    expect_val("line_start_found", 1); check(d_ls);
    t = 0; hs_low = 0; hs_first = -1; von = 0; pe_last = -1; pe_bad = 0; pe_n = 0;
    row0 = d_row; row_hold = 0; row_changed = 0; prev_col = -1; prev_von = 0; edge_ok = 0;
    do begin
      if (!d_hs) begin hs_low++; if (hs_first < 0) hs_first = t; end
      if (d_von) von++;
      if (d_pe) begin
        if (pe_last >= 0 && t - pe_last != 4) pe_bad++;
        pe_last = t;
        pe_n++;
      end
      if (!row_changed && d_row == row0) row_hold++; else row_changed = 1;
      if (prev_col == 639 && d_col == 640) edge_ok = prev_von && !d_von;
      prev_col = d_col;
      prev_von = d_von;
      @(negedge clock);
      t++;
    end while (!d_ls && t < 4000);
    expect_val("line_period", 3200);    check(t);
    expect_val("pix_en_gap_bad", 0);    check(pe_bad);
    expect_val("pix_en_per_line", 800); check(pe_n);
    expect_val("hs_low_clocks", 384);   check(hs_low);
    expect_val("hs_start", 2624);       check(hs_first);
    expect_val("video_on_clocks", 2560); check(von);
    expect_val("col_639_640_edge", 1);  check(edge_ok);
    expect_val("row_first", 1);         check(row0);
    expect_val("row_hold", 3200);       check(row_hold);
    expect_val("row_next", 2);          check(d_row);

    rst = 1'b1;
    repeat (2) @(negedge clock);
    rst = 1'b0;
    n = 0;
    while (!s_fs && n < 300) begin @(negedge clock); n++; end
    expect_val("frame_start_found", 1); check(s_fs);
    expect_val("fc1", 1); expect_val("fc2", 2); expect_val("fc3", 3);
    expect_val("fc4", 0); expect_val("fc5", 1);
    fs_seen = 0; t = 0; last_fs = -1; last_ls = -1; per_bad = 0; coinc_bad = 0; fc_bad = 0;
    ls_bad = 0; ls_n = 0; vs_low = 0; vs_bad = 0; sc_n = 0; sc_bad = 0;
    p_hs_n = 0; p_vs_n = 0; pol_bad = 0; prev_fc = s_fc;
    while (fs_seen < 5 && t < 600) begin
      if (s_fs) begin
        check(s_fc);
        fs_seen++;
        if (last_fs >= 0 && t - last_fs != 98) per_bad++;
        last_fs = t;
        if (!s_ls) coinc_bad++;
      end else if (s_fc != 2'(prev_fc)) fc_bad++;
      prev_fc = s_fc;
      if (s_ls) begin
        if (last_ls >= 0 && t - last_ls != 14) ls_bad++;
        last_ls = t;
      end
      if (fs_seen == 1) begin
        ls_n += s_ls;
        if (!s_vs) begin vs_low++; if (s_row != 5) vs_bad++; end
        else if (s_row == 5) vs_bad++;
        if (s_col == 7) begin sc_n++; if (s_scol != 3) sc_bad++; end
        if (p_hs !== (p_col == 10 || p_col == 11)) pol_bad++;
        if (p_vs !== (p_row == 5)) pol_bad++;
        p_hs_n += p_hs;
        p_vs_n += p_vs;
      end
      @(negedge clock);
      t++;
    end
    expect_val("frames_seen", 5);        check(fs_seen);
    expect_val("frame_period_bad", 0);   check(per_bad);
    expect_val("fs_ls_coincide_bad", 0); check(coinc_bad);
    expect_val("fc_change_off_fs", 0);   check(fc_bad);
    expect_val("line_period_bad", 0);    check(ls_bad);
    expect_val("lines_per_frame", 7);    check(ls_n);
    expect_val("vs_low_clocks", 14);     check(vs_low);
    expect_val("vs_row_bad", 0);         check(vs_bad);
    expect_val("col7_seen", 7);          check(sc_n);
    expect_val("scaled_col_bad", 0);     check(sc_bad);
    expect_val("pol_hs_high", 14);       check(p_hs_n);
    expect_val("pol_vs_high", 14);       check(p_vs_n);
    expect_val("pol_window_bad", 0);     check(pol_bad);

    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $error("FAIL scoreboard_leftover observed=%0d expected=0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Parametrised VGA display timing generator running from the single 100 MHz system clock, replacing the fixed 640x480 timing generator and its DCM-derived 25 MHz pixel clock.
- Produces an internal pixel-rate enable, the sync pulses, video-on, and raw and down-scaled pixel coordinates.
- Adds frame/line start pulses and a frame counter for the game logic.
- Feeds the colorizer and the video game controller.

## Interface
Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BP, 33, vertical back porch (lines)
- CLK_DIV, 4, system clocks per pixel; must be at least 1
- SCALE_SHIFT, 2, right-shift applied to produce scaled coordinates
- HS_POL, 0, active level of horiz_sync (0 = active-low)
- VS_POL, 0, active level of vert_sync
- CNT_W, 10, coordinate counter width; H_TOTAL and V_TOTAL must each be at most 2^CNT_W
- FRAME_W, 8, frame counter width

Ports:
- clock  in  1  system clock (100 MHz)
- rst  in  1  reset, synchronous, active-high
- pix_en  out  1  one-clock pixel-rate enable
- horiz_sync  out  1  horizontal sync
- vert_sync  out  1  vertical sync
- video_on  out  1  high inside the active area
- pixel_row  out  CNT_W  vertical counter value
- pixel_column  out  CNT_W  horizontal counter value
- scaled_row  out  CNT_W  pixel_row >> SCALE_SHIFT
- scaled_col  out  CNT_W  pixel_column >> SCALE_SHIFT
- line_start  out  1  one-clock pulse when hcnt enters 0
- frame_start  out  1  one-clock pulse when (hcnt,vcnt) enters (0,0)
- frame_count  out  FRAME_W  completed-frame count, wraps modulo 2^FRAME_W

## Operation
- Totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800 by default); V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525 by default).
- Divider `div`:
  - Counts 0..CLK_DIV-1 and wraps.
  - pix_en = (div == CLK_DIV-1), registered.
  - With CLK_DIV = 1, pix_en is high every clock after reset.
- Counters `hcnt`/`vcnt` change only in clocks where pix_en is high:
  - hcnt increments; at H_TOTAL-1 it wraps to 0.
  - vcnt increments on an hcnt wrap; at V_TOTAL-1 it wraps to 0.
- Decodes, all registered from the current counter values every clock:
  - video_on = (hcnt < H_ACTIVE) && (vcnt < V_ACTIVE).
  - horiz_sync = HS_POL while hcnt is in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1], otherwise ~HS_POL.
  - vert_sync = VS_POL while vcnt is in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1], otherwise ~VS_POL.
  - pixel_column = hcnt and pixel_row = vcnt, including in the blanking intervals; consumers qualify with video_on.
  - scaled_* are logical right shifts of the same registered values; no rounding.
- Pulses:
  - line_start is high for exactly one clock after hcnt wraps to 0.
  - frame_start is high for exactly one clock after both counters wrap to 0, coincident with that line_start.
  - frame_count increments by 1 in the same clock frame_start rises, and wraps from 2^FRAME_W-1 to 0.

## Timing
- Reset values (in the clock after rst is sampled high):
  - div, hcnt, vcnt, pixel_row, pixel_column, scaled_*, frame_count, pix_en, line_start, frame_start, video_on all 0.
  - horiz_sync = ~HS_POL and vert_sync = ~VS_POL (inactive).
- Reset asserted mid-frame overrides all activity in the same clock; no partial pulse is emitted.
- The state after reset does not itself generate line_start or frame_start.
- After rst deasserts, taking the first clock with rst = 0 as cycle 0:
  - Decodes reflect (0,0) from cycle 1: video_on = 1, coordinates 0.
  - The first pix_en is high in cycle CLK_DIV (registered decode of div == CLK_DIV-1).
- Counter-to-output latency is exactly 1 clock for all decoded outputs and pulses.
- Each counter state persists for exactly CLK_DIV clocks.
- Line period is H_TOTAL×CLK_DIV clocks; frame period is H_TOTAL×V_TOTAL×CLK_DIV clocks (1,680,000 by default).

## Test plan
- Reset: hold rst for 3 clocks mid-frame -> all outputs at the reset values above, syncs high (defaults); after release, video_on = 1 from cycle 1 and the first pix_en at cycle 4.
- Default horizontal timing: measure one line -> pix_en period 4 clocks; horiz_sync low for exactly 384 clocks, starting 656×4 clocks after line_start; video_on high for 2560 clocks per visible line.
- Small config (H 8/2/2/2, V 4/1/1/1, CLK_DIV=1, SCALE_SHIFT=1):
  - line_start every 14 clocks; frame_start every 98 clocks.
  - vert_sync low for 14 clocks while pixel_row = 5.
  - scaled_col = 3 when pixel_column = 7.
- Frame counter wrap (small config, FRAME_W=2): run 5 frames -> frame_count sequence 1, 2, 3, 0, 1, each change coincident with frame_start.
- Polarity (HS_POL=1, VS_POL=1): horiz_sync and vert_sync low at reset and high only inside their sync windows.
- Coordinate continuity (defaults): pixel_column goes 639→640 with video_on falling in the same clock; pixel_row holds for 3200 clocks per line.
